instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the fetch PC and drives the byte address into the combinational instruction memory.
- Captures the returned word, together with its PC, into a small prefetch FIFO.
- Presents FIFO entries to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and reloading the PC.

Parameters:
- ADDR_BITS, 8, byte-address width of instruction memory (64 words x 4 bytes).
- WORD_BITS, 32, instruction width; must be a multiple of 8.
- RESET_PC, 0, byte address fetched first after reset; must be word-aligned.
- FIFO_DEPTH, 4, prefetch entries; power of two, >= 2.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  when 0, no new fetches are issued; FIFO still drains.
- imem_address  output  ADDR_BITS  byte address to instruction memory.
- imem_rd_data  input  WORD_BITS  word at imem_address, valid in the same cycle (combinational memory).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDR_BITS  new fetch byte address.
- out_valid  output  1  FIFO head holds an instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  WORD_BITS  instruction at FIFO head.
- out_pc  output  ADDR_BITS  byte address of out_instr.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - fetch_pc <= RESET_PC; FIFO count, read and write pointers <= 0.
  - out_valid=0; out_instr=0 and out_pc=0 while empty (storage is not reset, so outputs are masked when empty).
  - imem_address=RESET_PC.
  - Reset asserted mid-operation discards all entries immediately, with no partial state.
- imem_address is driven directly from the fetch_pc register: no combinational input-to-address path.
- Word alignment: the low $clog2(WORD_BITS/8) bits of fetch_pc are always 0. redirect_pc low bits are forced to 0 on load.
- pop = out_valid & out_ready.
- push = fetch_en & !redirect_valid & (count < FIFO_DEPTH | pop). A push is allowed into a full FIFO when a pop occurs in the same cycle.
- On push:
  - FIFO[wr_ptr] <= {fetch_pc, imem_rd_data}.
  - fetch_pc <= fetch_pc + WORD_BITS/8, wrapping modulo 2^ADDR_BITS (e.g. 0xFC -> 0x00 at defaults).
- On no push and no redirect: fetch_pc holds.
- Count update: count +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo FIFO_DEPTH.
- Redirect (highest priority):
  - In the cycle redirect_valid=1, the head is still presented and a pop may complete (handshake honoured).
  - At the next edge: FIFO flushed (count, pointers <= 0), fetch_pc <= aligned redirect_pc, no push.
  - out_valid=0 the cycle after a redirect.
  - The first redirected instruction appears on out_* 2 cycles after the redirect edge: one edge to load the PC, one to push.
- Latency:
  - Fetch-to-output is 1 cycle: the word pushed at edge N is visible at out_* after edge N when the FIFO was empty.
  - After rst_n deasserts, the first push occurs at the first clk edge if fetch_en=1, so out_valid=1 after that edge.
- Throughput is 1 instruction/cycle sustained when out_ready=1.
- out_valid, out_instr and out_pc are stable while out_valid=1 and out_ready=0, absent a redirect.
- fetch_en=0: no push, fetch_pc holds; pops continue. Re-asserting resumes from the held fetch_pc with no skipped or duplicated address.
- No X propagation: out_instr and out_pc are forced to 0 whenever out_valid=0.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, memory word i = 0x1000_0000+i -> out_valid rises after 1st edge; out_pc 0x00,0x04,0x08… with out_instr 0x1000_0000,0x1000_0001,… one per cycle, no gaps.
- out_ready=0 for 8 cycles -> exactly 4 entries (pcs 0x00–0x0C) held; imem_address frozen at 0x10; out_* stable. out_ready=1 -> drains in order, then 0x10 follows with no bubble. Full plus simultaneous pop sustains 1/cycle.
- Redirect to 0x42 while FIFO holds 3 entries and out_ready=1 -> head popped in redirect cycle; next cycle out_valid=0 and imem_address=0x40; following cycle out_pc=0x40; no stale entries ever appear.
- Sequential fetch from 0xF8 -> out_pc sequence 0xF8,0xFC,0x00,0x04 (address wrap).
- fetch_en toggled 0 for 3 cycles mid-stream -> FIFO drains to empty with out_valid=0; on re-enable fetch resumes at the next sequential pc with no duplicate or skip.
- rst_n pulsed low asynchronously (between edges) with FIFO full -> out_valid=0 and imem_address=RESET_PC immediately; after release, stream restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Owns the fetch PC, reads the combinational instruction memory, and buffers
// {pc, instruction} pairs in a small prefetch FIFO that decode drains over a
// valid/ready handshake. A redirect flushes the FIFO and reloads the PC.
module instruction_fetch_unit #(
    parameter int          ADDR_BITS  = 8,
    parameter int          WORD_BITS  = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    output logic [ADDR_BITS-1:0] imem_address,
    input  logic [WORD_BITS-1:0] imem_rd_data,
    input  logic                 redirect_valid,
    input  logic [ADDR_BITS-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_instr,
    output logic [ADDR_BITS-1:0] out_pc
);

    localparam int BYTES_PER_WORD = WORD_BITS / 8;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int CNT_W          = PTR_W + 1;

    // Byte step between sequential fetches and the mask that clears the
    // sub-word address bits so every fetch stays word-aligned.
    localparam logic [ADDR_BITS-1:0] PC_STEP    = ADDR_BITS'(BYTES_PER_WORD);
    localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_BITS-1:0] RESET_ADDR = ADDR_BITS'(RESET_PC) & ALIGN_MASK;
    localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [ADDR_BITS-1:0] fetch_pc;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;

    // Storage is deliberately left out of reset; outputs are masked while
    // the FIFO is empty so stale contents never leak out.
    logic [ADDR_BITS-1:0] pc_mem    [FIFO_DEPTH];
    logic [WORD_BITS-1:0] instr_mem [FIFO_DEPTH];

    logic pop;
    logic push;

    // The address comes straight from a register, so there is no
    // combinational path from any input to the memory address.
    assign imem_address = fetch_pc;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // A full FIFO can still accept a word when the head leaves in the same
    // cycle, which is what keeps throughput at one instruction per cycle.
    assign push = fetch_en & ~redirect_valid & ((count < FULL_COUNT) | pop);

    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

    // Capture the returned word together with the address it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rd_data;
        end
    end

    // Fetch PC: redirect wins, otherwise advance one word per push, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_ADDR;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ALIGN_MASK;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // FIFO bookkeeping: a redirect flushes everything, otherwise pointers
    // advance on push/pop and the occupancy tracks the net change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
